// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: strobes columns, debounces whole-matrix frames, resolves a
// single pressed key and queues press/release events for a valid/ready consumer.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int REPORT_REL = 1,
  localparam int KW        = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [COLS-1:0] col_drive,
  input  logic [ROWS-1:0] row_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_key,
  output logic            evt_release,
  output logic            overflow
);

  // Handshake: an event transfers on a cycle where evt_valid && evt_ready; while
  // evt_valid is high and evt_ready low, evt_key/evt_release hold the same head entry.

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEB_MAX    = SW'(DEBOUNCE);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);

  logic [ROWS-1:0] row_m, row_s;

  logic            running;
  logic [CW-1:0]   col_idx, next_col;
  logic [DW-1:0]   dwell;
  logic            capture, frame_done;

  // Frames are stored pressed-high, indexed [col][row].
  logic [COLS-1:0][ROWS-1:0] work_frame, cur_frame, prev_frame;
  logic [SW-1:0]   stable_cnt, stable_nxt;
  logic            same, saturated, accept;

  logic [1:0]      n_hits;
  logic [KW-1:0]   res_idx;
  logic            res_hit, key_change;
  logic            key_valid;
  logic [KW-1:0]   key_idx;
  logic            pend_valid;
  logic [KW-1:0]   pend_key;

  logic            push, push_rel, set_pend;
  logic [KW-1:0]   push_key;

  logic [KW:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            pop, full, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  assign capture    = running && (dwell == LAST_DWELL);
  assign frame_done = capture && (col_idx == LAST_COL);
  assign next_col   = (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;

  always_comb begin
    cur_frame          = work_frame;
    cur_frame[col_idx] = ~row_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running    <= 1'b0;
      col_idx    <= '0;
      dwell      <= '0;
      col_drive  <= '1;
      work_frame <= '0;
    end else if (!running) begin
      running   <= 1'b1;
      col_drive <= ~COLS'(1);
    end else if (capture) begin
      work_frame <= cur_frame;
      dwell      <= '0;
      col_idx    <= next_col;
      col_drive  <= ~(COLS'(1) << next_col);
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Accept exactly once, on the completion where the run of identical frames reaches DEBOUNCE.
  assign same       = (cur_frame == prev_frame);
  assign saturated  = same && (stable_cnt == DEB_MAX);
  assign stable_nxt = !same ? SW'(1) : (saturated ? stable_cnt : stable_cnt + 1'b1);
  assign accept     = frame_done && !saturated && (stable_nxt == DEB_MAX);

  always_comb begin
    n_hits  = 2'd0;
    res_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cur_frame[c][r]) begin
          if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
          res_idx = KW'(r*COLS + c);
        end
      end
    end
  end

  assign res_hit    = (n_hits == 2'd1);
  assign key_change = accept && (n_hits != 2'd2) &&
                      ((res_hit != key_valid) || (res_hit && (res_idx != key_idx)));

  // A K -> J change queues the release now and parks the press for the next cycle.
  always_comb begin
    push     = 1'b0;
    push_rel = 1'b0;
    push_key = '0;
    set_pend = 1'b0;
    if (pend_valid) begin
      push     = 1'b1;
      push_key = pend_key;
    end else if (key_change) begin
      if (!key_valid) begin
        push     = 1'b1;
        push_key = res_idx;
      end else if (REPORT_REL != 0) begin
        push     = 1'b1;
        push_rel = 1'b1;
        push_key = key_idx;
        set_pend = res_hit;
      end else if (res_hit) begin
        push     = 1'b1;
        push_key = res_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_frame <= '0;
      stable_cnt <= '0;
      key_valid  <= 1'b0;
      key_idx    <= '0;
      pend_valid <= 1'b0;
      pend_key   <= '0;
    end else begin
      pend_valid <= set_pend;
      if (set_pend) pend_key <= res_idx;
      if (frame_done) begin
        prev_frame <= cur_frame;
        stable_cnt <= stable_nxt;
      end
      if (key_change) begin
        key_valid <= res_hit;
        key_idx   <= res_idx;
      end
    end
  end

  assign pop     = evt_valid && evt_ready;
  assign full    = (count == FULL_CNT);
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= {push_rel, push_key};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  assign evt_valid              = (count != '0);
  assign {evt_release, evt_key} = mem[rd_ptr];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized key sequences checked
// against a frame-level debounce/event model.
module tb_keypad_scanner;

  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_drive;
  logic [3:0]  row_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_key;
  logic        evt_release;
  logic        overflow;

  logic [15:0] keys;
  logic        rand_rdy;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [4:0]  exp_q[$];
  logic [4:0]  act_q[$];
  int          act_t[$];
  int          cyc = 0;
  int          ovf_cnt = 0;
  int          stab_viol = 0;
  logic [15:0] m_prev = '0;
  int          m_run = 0;
  int          m_key = -1;
  logic [3:0]  prev_col = '1;
  logic        had_valid = 1'b0;
  logic [4:0]  held = '0;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB), .FIFO_DEPTH(4), .REPORT_REL(1)
  ) dut (
    .clk(clk), .rst(rst), .col_drive(col_drive), .row_in(row_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_release(evt_release), .overflow(overflow)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col_drive[c]) row_in[r] = 1'b0;
  end

  // ---- monitor and reference model ----
  always @(negedge clk) begin
    int run_n;
    int nk;
    int idx;
    int newk;
    if (rst) begin
      m_prev    <= '0;
      m_run     <= 0;
      m_key     <= -1;
      prev_col  <= '1;
      had_valid <= 1'b0;
    end else begin
      if (col_drive == 4'b1110 && prev_col != 4'b1110) begin
        run_n = (keys == m_prev) ? m_run + 1 : 1;
        m_run  <= run_n;
        m_prev <= keys;
        if (run_n == DEB) begin
          nk  = $countones(keys);
          idx = -1;
          for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
          if (nk <= 1) begin
            newk = (nk == 1) ? idx : -1;
            if (newk != m_key) begin
              if (m_key >= 0) exp_q.push_back({1'b1, m_key[3:0]});
              if (newk >= 0)  exp_q.push_back({1'b0, newk[3:0]});
              m_key <= newk;
            end
          end
        end
      end
      prev_col <= col_drive;
      if (had_valid && (!evt_valid || {evt_release, evt_key} !== held))
        stab_viol <= stab_viol + 1;
      had_valid <= evt_valid && !evt_ready;
      held      <= {evt_release, evt_key};
      if (evt_valid && evt_ready) begin
        act_q.push_back({evt_release, evt_key});
        act_t.push_back(cyc);
      end
      if (overflow) ovf_cnt <= ovf_cnt + 1;
    end
  end

  // ---- driver tasks ----
  task automatic sync_frame();
    logic [3:0] last;
    logic       found;
    last  = col_drive;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) evt_ready = ($urandom_range(0, 1) == 1);
      if (col_drive == 4'b1110 && last != 4'b1110) found = 1'b1;
      last = col_drive;
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_start_timeout col_drive=%b want a 1110 strobe within 40 clks", col_drive);
    end
  endtask

  task automatic hold(input logic [15:0] pat, input int nframes);
    for (int i = 0; i < nframes; i++) begin
      sync_frame();
      keys = pat;
    end
  endtask

  task automatic settle();
    sync_frame();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [3:0] want;
    rst = 1'b1;
    keys = '0;
    evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (col_drive !== 4'b1111) begin n_fail++; $display("FAIL reset_col got %b want 1111", col_drive); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    n_cmp++; if (evt_key !== 4'd0) begin n_fail++; $display("FAIL reset_key got %0d want 0", evt_key); end
    n_cmp++; if (evt_release !== 1'b0) begin n_fail++; $display("FAIL reset_release got %b want 0", evt_release); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      want = ~(4'b0001 << ((i / 4) % 4));
      n_cmp++; if (col_drive !== want) begin n_fail++; $display("FAIL scan_col cycle %0d got %b want %b", i, col_drive, want); end
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid cycle %0d got %b want 0", i, evt_valid); end
    end
  endtask

  task automatic test_single_key();
    int base;
    logic [4:0] want[2];
    logic [4:0] got;
    want[0] = {1'b0, 4'd6};
    want[1] = {1'b1, 4'd6};
    base = act_q.size();
    hold(16'(1) << 6, 3);
    hold('0, 3);
    settle();
    n_cmp++; if (act_q.size() - base !== 2) begin n_fail++; $display("FAIL single_count got %0d want 2", act_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      got = (base + i < act_q.size()) ? act_q[base + i] : 5'bx;
      n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL single_evt%0d got %h want %h", i, got, want[i]); end
    end
  endtask

  task automatic test_glitch();
    int base;
    base = act_q.size();
    hold(16'(1) << 9, 1);
    hold('0, 3);
    settle();
    n_cmp++; if (act_q.size() - base !== 0) begin n_fail++; $display("FAIL glitch_count got %0d want 0", act_q.size() - base); end
  endtask

  task automatic test_multi_key();
    int base;
    logic [4:0] want[2];
    logic [4:0] got;
    want[0] = {1'b0, 4'd5};
    want[1] = {1'b1, 4'd5};
    base = act_q.size();
    hold((16'(1) << 0) | (16'(1) << 5), 3);
    n_cmp++; if (act_q.size() - base !== 0 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL multi_ignored got %0d events valid=%b want 0 events", act_q.size() - base, evt_valid);
    end
    hold(16'(1) << 5, 3);
    hold('0, 3);
    settle();
    n_cmp++; if (act_q.size() - base !== 2) begin n_fail++; $display("FAIL multi_count got %0d want 2", act_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      got = (base + i < act_q.size()) ? act_q[base + i] : 5'bx;
      n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL multi_evt%0d got %h want %h", i, got, want[i]); end
    end
  endtask

  task automatic test_transition();
    int base;
    int gap;
    logic [4:0] want[4];
    logic [4:0] got;
    want[0] = {1'b0, 4'd3};
    want[1] = {1'b1, 4'd3};
    want[2] = {1'b0, 4'd12};
    want[3] = {1'b1, 4'd12};
    base = act_q.size();
    hold(16'(1) << 3, 3);
    hold(16'(1) << 12, 3);
    hold('0, 3);
    settle();
    n_cmp++; if (act_q.size() - base !== 4) begin n_fail++; $display("FAIL trans_count got %0d want 4", act_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < act_q.size()) ? act_q[base + i] : 5'bx;
      n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL trans_evt%0d got %h want %h", i, got, want[i]); end
    end
    gap = (act_q.size() - base >= 3) ? act_t[base + 2] - act_t[base + 1] : -1;
    n_cmp++; if (gap !== 1) begin n_fail++; $display("FAIL trans_gap got %0d cycles want 1", gap); end
  endtask

  task automatic test_overflow();
    int base;
    int obase;
    int sbase;
    logic [4:0] want[5];
    logic [4:0] got;
    want[0] = {1'b0, 4'd1};
    want[1] = {1'b1, 4'd1};
    want[2] = {1'b0, 4'd2};
    want[3] = {1'b1, 4'd2};
    want[4] = {1'b1, 4'd3};
    base  = act_q.size();
    obase = ovf_cnt;
    sbase = stab_viol;
    evt_ready = 1'b0;
    hold(16'(1) << 1, 2);
    hold('0, 2);
    hold(16'(1) << 2, 2);
    hold('0, 2);
    hold(16'(1) << 3, 2);
    settle();
    n_cmp++; if (ovf_cnt - obase !== 1) begin n_fail++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - obase); end
    n_cmp++; if (evt_valid !== 1'b1 || {evt_release, evt_key} !== want[0]) begin
      n_fail++; $display("FAIL ovf_head got valid=%b %h want valid=1 %h", evt_valid, {evt_release, evt_key}, want[0]);
    end
    evt_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got valid=%b want 0", evt_valid); end
    hold('0, 3);
    settle();
    n_cmp++; if (act_q.size() - base !== 5) begin n_fail++; $display("FAIL ovf_count got %0d want 5", act_q.size() - base); end
    for (int i = 0; i < 5; i++) begin
      got = (base + i < act_q.size()) ? act_q[base + i] : 5'bx;
      n_cmp++; if (got !== want[i]) begin n_fail++; $display("FAIL ovf_evt%0d got %h want %h", i, got, want[i]); end
    end
    n_cmp++; if (stab_viol - sbase !== 0) begin n_fail++; $display("FAIL ovf_hold_stable got %0d violations want 0", stab_viol - sbase); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [3:0] want;
    logic [4:0] got;
    evt_ready = 1'b0;
    hold(16'(1) << 4, 2);
    hold('0, 2);
    hold(16'(1) << 7, 2);
    sync_frame();
    n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued got valid=%b want 1", evt_valid); end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (col_drive !== 4'b1111) begin n_fail++; $display("FAIL mid_col got %b want 1111", col_drive); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", evt_valid); end
    n_cmp++; if (evt_key !== 4'd0 || evt_release !== 1'b0) begin
      n_fail++; $display("FAIL mid_head got %h want 00", {evt_release, evt_key});
    end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %b want 0", overflow); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    base = act_q.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      want = (i < 4) ? 4'b1110 : 4'b1101;
      n_cmp++; if (col_drive !== want) begin n_fail++; $display("FAIL mid_restart cycle %0d got %b want %b", i, col_drive, want); end
    end
    repeat (4) sync_frame();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (act_q.size() - base !== 1) begin n_fail++; $display("FAIL mid_after_count got %0d want 1", act_q.size() - base); end
    got = (act_q.size() > base) ? act_q[base] : 5'bx;
    n_cmp++; if (got !== {1'b0, 4'd7}) begin n_fail++; $display("FAIL mid_after_evt got %h want 07", got); end
    hold('0, 3);
    settle();
  endtask

  task automatic test_random();
    int abase;
    int ebase;
    int sbase;
    int na;
    int ne;
    int k1;
    int k2;
    logic [15:0] pat;
    abase = act_q.size();
    ebase = exp_q.size();
    sbase = stab_viol;
    rand_rdy = 1'b1;
    for (int s = 0; s < 16; s++) begin
      k1 = $urandom_range(0, 15);
      k2 = (k1 + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0:       pat = '0;
        3:       pat = (16'(1) << k1) | (16'(1) << k2);
        default: pat = 16'(1) << k1;
      endcase
      hold(pat, $urandom_range(1, 3));
    end
    hold('0, 3);
    rand_rdy = 1'b0;
    evt_ready = 1'b1;
    settle();
    na = act_q.size() - abase;
    ne = exp_q.size() - ebase;
    n_cmp++; if (na !== ne) begin n_fail++; $display("FAIL rand_count got %0d want %0d", na, ne); end
    for (int i = 0; i < ne && i < na; i++) begin
      n_cmp++; if (act_q[abase + i] !== exp_q[ebase + i]) begin
        n_fail++; $display("FAIL rand_evt%0d got %h want %h", i, act_q[abase + i], exp_q[ebase + i]);
      end
    end
    n_cmp++; if (stab_viol - sbase !== 0) begin n_fail++; $display("FAIL rand_hold_stable got %0d violations want 0", stab_viol - sbase); end
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    evt_ready = 1'b0;
    rand_rdy = 1'b0;
    test_reset();
    test_single_key();
    test_glitch();
    test_multi_key();
    test_transition();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
